// File: rtl/tx_pkg.sv
// Shared framing constants, state type and default buffer depth for the TX framer.
package tx_pkg;

    localparam logic [6:0]  TX_START      = 7'h00;
    localparam logic [6:0]  TX_STOP       = 7'h7F;
    localparam int unsigned DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/tx_fifo.sv
// Character buffer for the TX framer: power-of-two circular FIFO with
// wrapping pointers and an occupancy count one bit wider than the pointers.
module tx_fifo
    import tx_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [6:0]               din,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [6:0]               dout
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [6:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_COUNT);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !reset) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/tx_framer.sv
// Buffers CPU-written ASCII characters and, on flush, emits them as a frame
// START(00), data..., STOP(7F) on a registered 7-bit tx stream.
module tx_framer
    import tx_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [6:0] wr_data,
    input  logic       flush,
    output logic       ready,
    output logic [6:0] tx,
    output logic       busy,
    output logic       err
);

    tx_state_e state_q, state_d;
    logic       flush_q, flush_d;
    logic       err_q, err_d;
    logic [6:0] tx_q, tx_d;

    logic                   fifo_push, fifo_pop;
    logic                   fifo_empty, fifo_full;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [6:0]             fifo_dout;
    logic                   ready_int, wr_ok;

    tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (wr_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count),
        .dout  (fifo_dout)
    );

    always_comb begin
        ready_int = !reset && (state_q == ST_IDLE) && !fifo_full && !flush_q;
        wr_ok     = wr_en && ready_int && (wr_data != TX_START) && (wr_data != TX_STOP);
        fifo_push = wr_ok;
        fifo_pop  = 1'b0;
        state_d   = state_q;
        flush_d   = flush_q;
        err_d     = err_q;
        tx_d      = TX_STOP;

        if (wr_en && !wr_ok) err_d = 1'b1;
        if (flush) begin
            if (!ready_int)                err_d   = 1'b1;
            else if (!fifo_empty || wr_ok) flush_d = 1'b1;
        end

        // tx_d is what tx shows while in state_d, so tx stays aligned with busy.
        case (state_q)
            ST_IDLE: begin
                if (flush_q) begin
                    state_d = ST_START;
                    flush_d = 1'b0;
                    tx_d    = TX_START;
                end
            end
            ST_START: begin
                state_d  = ST_DATA;
                fifo_pop = 1'b1;
                tx_d     = fifo_dout;
            end
            ST_DATA: begin
                if (fifo_count == '0) begin
                    state_d = ST_STOP;
                end else begin
                    fifo_pop = 1'b1;
                    tx_d     = fifo_dout;
                end
            end
            ST_STOP: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            flush_q <= 1'b0;
            err_q   <= 1'b0;
            tx_q    <= TX_STOP;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            err_q   <= err_d;
            tx_q    <= tx_d;
        end
    end

    assign ready = ready_int;
    assign tx    = tx_q;
    assign busy  = (state_q != ST_IDLE);
    assign err   = err_q;

endmodule

// File: tb/tb_tx_framer.sv
// Directed and randomized checks of tx_framer against a queue-based frame timeline model.
module tb_tx_framer;

    localparam int unsigned DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [6:0] wr_data = '0;
    logic       flush = 1'b0;
    logic       ready;
    logic [6:0] tx;
    logic       busy;
    logic       err;

    int unsigned tests = 0;
    int unsigned fails = 0;

    typedef struct {
        logic [6:0] tx;
        bit         busy;
    } slot_t;

    slot_t      timeline[$];
    logic [6:0] buffered[$];
    bit         m_err = 1'b0;
    logic [6:0] m_tx = 7'h7F;
    bit         m_busy = 1'b0;

    tx_framer #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .flush   (flush),
        .ready   (ready),
        .tx      (tx),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic step(input bit r, input bit we, input logic [6:0] wd, input bit fl);
        bit   exp_ready;
        slot_t s;
        @(negedge clk);
        reset   = r;
        wr_en   = we;
        wr_data = wd;
        flush   = fl;
        #1;
        exp_ready = !r && (timeline.size() == 0) && (buffered.size() < DEPTH);
        tests++;
        assert (ready === exp_ready) else begin
            fails++;
            $error("FAIL ready: got %b expected %b", ready, exp_ready);
        end

        if (r) begin
            buffered.delete();
            timeline.delete();
            m_err  = 1'b0;
            m_tx   = 7'h7F;
            m_busy = 1'b0;
        end else begin
            if (we) begin
                if (!exp_ready || wd == 7'h00 || wd == 7'h7F) m_err = 1'b1;
                else buffered.push_back(wd);
            end
            if (fl) begin
                if (!exp_ready) m_err = 1'b1;
                else if (buffered.size() > 0) begin
                    timeline.push_back('{7'h7F, 1'b0});
                    timeline.push_back('{7'h00, 1'b1});
                    foreach (buffered[i]) timeline.push_back('{buffered[i], 1'b1});
                    timeline.push_back('{7'h7F, 1'b1});
                    timeline.push_back('{7'h7F, 1'b0});
                    buffered.delete();
                end
            end
            if (timeline.size() > 0) begin
                s = timeline.pop_front();
                m_tx   = s.tx;
                m_busy = s.busy;
            end else begin
                m_tx   = 7'h7F;
                m_busy = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        tests++;
        assert (tx === m_tx) else begin
            fails++;
            $error("FAIL tx: got %h expected %h", tx, m_tx);
        end
        tests++;
        assert (busy === m_busy) else begin
            fails++;
            $error("FAIL busy: got %b expected %b", busy, m_busy);
        end
        tests++;
        assert (err === m_err) else begin
            fails++;
            $error("FAIL err: got %b expected %b", err, m_err);
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 7'h00, 1'b0);
    endtask

    task automatic write(input logic [6:0] c);
        step(1'b0, 1'b1, c, 1'b0);
    endtask

    initial begin
        // Reset, "Hi", flush
        step(1'b1, 1'b0, 7'h00, 1'b0);
        idle(1);
        write(7'h48);
        write(7'h69);
        step(1'b0, 1'b0, 7'h00, 1'b1);
        idle(6);

        // Write + flush in the same cycle on an empty buffer
        step(1'b0, 1'b1, 7'h41, 1'b1);
        idle(5);

        // Flush on an empty buffer is ignored
        step(1'b0, 1'b0, 7'h00, 1'b1);
        idle(2);

        // Fill to DEPTH, overflow write and flush while full
        step(1'b1, 1'b0, 7'h00, 1'b0);
        for (int unsigned i = 0; i < DEPTH; i++) write(7'h61 + 7'(i));
        write(7'h7A);
        step(1'b0, 1'b0, 7'h00, 1'b1);
        idle(1);

        // Framing characters are rejected
        step(1'b1, 1'b0, 7'h00, 1'b0);
        write(7'h7F);
        write(7'h00);
        step(1'b0, 1'b0, 7'h00, 1'b1);
        idle(2);

        // "HELLO", reset while the third data character is on tx
        step(1'b1, 1'b0, 7'h00, 1'b0);
        write(7'h48); write(7'h45); write(7'h4C); write(7'h4C); write(7'h4F);
        step(1'b0, 1'b0, 7'h00, 1'b1);
        idle(4);
        step(1'b1, 1'b0, 7'h00, 1'b0);
        idle(2);
        step(1'b0, 1'b0, 7'h00, 1'b1);
        idle(2);

        // Write during DATA is dropped, frame unchanged
        step(1'b1, 1'b0, 7'h00, 1'b0);
        write(7'h31); write(7'h32); write(7'h33);
        step(1'b0, 1'b0, 7'h00, 1'b1);
        idle(2);
        write(7'h34);
        idle(5);

        // Randomized traffic
        step(1'b1, 1'b0, 7'h00, 1'b0);
        for (int unsigned i = 0; i < 1500; i++) begin
            bit         r, we, fl;
            logic [6:0] wd;
            r  = ($urandom_range(0, 59) == 0);
            we = ($urandom_range(0, 1) == 1);
            fl = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 19))
                0:       wd = 7'h00;
                1:       wd = 7'h7F;
                default: wd = 7'($urandom_range(1, 126));
            endcase
            step(r, we, wd, fl);
        end
        idle(DEPTH + 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tx_framer.md
TX_FRAMER -- requirements
Module: tx_framer

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the character buffer depth in entries (power of two, 2..64).
REQ-002 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 wr_en  input  1  character write strobe from the CPU store path.
REQ-005 wr_data  input  7  character to buffer, 7-bit ASCII.
REQ-006 flush  input  1  end-of-message strobe; requests transmission of all buffered characters.
REQ-007 ready  output  1  high when a write or flush is accepted this cycle.
REQ-008 tx  output  7  registered framed character stream to the pins.
REQ-009 busy  output  1  high while a frame (start, data or stop) is on tx.
REQ-010 err  output  1  sticky error flag; cleared only by reset.

Function
REQ-011 tx SHALL carry 7'h7F (STOP) when idle, 7'h00 (START) for one cycle to open a frame, then one buffered character per cycle, then 7'h7F to close.
REQ-012 ready SHALL equal (state==IDLE) AND (buffer not full) AND (no flush latched).
REQ-013 A write with wr_en=1 and ready=1 SHALL push wr_data into the buffer in that cycle.
REQ-014 A write with ready=0 SHALL be dropped and SHALL set err.
REQ-015 A write whose wr_data is 7'h00 or 7'h7F SHALL be dropped and SHALL set err, since it would corrupt framing.
REQ-016 States: IDLE, START, DATA, STOP; encoding comes from the package.
REQ-017 IDLE: a flush sampled with ready=1 and buffer non-empty (counting a same-cycle accepted write) SHALL move the block to START on the next edge.
REQ-018 IDLE: a flush with an empty buffer and no same-cycle write SHALL be ignored and SHALL NOT set err.
REQ-019 A flush with ready=0 SHALL be dropped and SHALL set err.
REQ-020 A write and a flush in the same IDLE cycle SHALL both be accepted, and the written character SHALL be the last character of the frame.
REQ-021 START SHALL drive tx=00 for exactly one cycle, then move to DATA.
REQ-022 DATA SHALL pop one character per cycle onto tx, in FIFO order, with no gaps.
REQ-023 DATA SHALL move to STOP after the cycle that outputs the last buffered character.
REQ-024 STOP SHALL drive tx=7F for one cycle, then move to IDLE.
REQ-025 Latency: for a flush sampled at edge N with L characters buffered (1<=L<=DEPTH), tx SHALL be 00 after edge N+1, characters after edges N+2..N+1+L, and 7F after edge N+2+L; ready SHALL return after edge N+3+L.
REQ-026 busy SHALL be high exactly in START, DATA and STOP.
REQ-027 The buffer SHALL hold exactly DEPTH characters.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH; the occupancy count SHALL be log2(DEPTH)+1 bits wide.
REQ-029 When the buffer is full, ready SHALL be low; a flush is therefore not accepted while full, so software must flush at DEPTH-1 characters or fewer.

Reset
REQ-030 When reset=1 at a rising edge, the block SHALL enter IDLE, empty the buffer, and clear the latched flush and err.
REQ-031 Outputs after a reset edge SHALL be: tx=7F, busy=0, err=0, and ready=1 (low while reset is held).
REQ-032 A reset during START, DATA or STOP SHALL abort the frame, with tx=7F on the next cycle and no further characters.
REQ-033 Reset SHALL take priority over all same-cycle wr_en and flush inputs.

Structure
REQ-034 Package tx_pkg SHALL hold TX_START=7'h00, TX_STOP=7'h7F, the state enum type, and the default DEPTH.
REQ-035 Buffering SHALL be a separate sub-module tx_fifo (push, pop, empty, full, count, dout).
REQ-036 tx_framer SHALL hold the state machine and the output register.

Verification
REQ-037 Reset, then write "Hi" and flush -> tx sequence 7F,00,'H','i',7F, with busy high for 4 cycles.
REQ-038 Write 'A' with flush in the same cycle on an empty buffer -> frame 00,'A',7F.
REQ-039 Flush on an empty buffer -> tx stays 7F, busy=0, err=0.
REQ-040 Write DEPTH characters -> ready=0 when full; one more write is dropped and err=1.
REQ-041 Write 7'h7F, then write 7'h00 -> both dropped, err=1, buffer stays empty.
REQ-042 Write "HELLO", flush, then assert reset during the third data character -> tx=7F the next cycle, buffer empty, ready=1 after reset is released.
REQ-043 Write during DATA -> dropped and err=1; the frame completes unchanged.
